// File: rtl/soc_decerr_slave_pkg.sv
// Shared SoC constants for the crossbar default slave.
// Response code and read filler pattern returned on decode errors.
package ariane_soc;

  localparam int unsigned IdWidthSlave = 6;

  localparam logic [1:0] AxiRespDecErr = 2'b11;

  localparam logic [63:0] DecErrRdata = 64'hBADC_AB1E_BADC_AB1E;

endpackage

// File: rtl/soc_decerr_slave_rd_gen.sv
// Read side of the decode-error slave.
// Accepts one AR, then returns ar_len+1 DECERR beats.
module soc_decerr_rd_gen
  import ariane_soc::*;
#(
  parameter int unsigned IdWidth   = IdWidthSlave,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i
);

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  rstate_e              state_q;
  logic [7:0]           cnt_q;
  logic                 ar_ready_q;
  logic                 r_valid_q;
  logic                 r_last_q;
  logic [IdWidth-1:0]   r_id_q;

  // Read FSM: counter holds the beats still to send after the current one
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= R_IDLE;
      cnt_q      <= '0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
    end else begin
      unique case (state_q)
        R_IDLE: begin
          if (ar_valid_i) begin
            state_q    <= R_DATA;
            cnt_q      <= ar_len_i;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b1;
            r_last_q   <= (ar_len_i == 8'd0);
            r_id_q     <= ar_id_i;
          end
        end
        R_DATA: begin
          if (r_ready_i) begin
            if (cnt_q == 8'd0) begin
              state_q    <= R_IDLE;
              ar_ready_q <= 1'b1;
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
            end else begin
              cnt_q    <= cnt_q - 8'd1;
              r_last_q <= (cnt_q == 8'd1);
            end
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign ar_ready_o = ar_ready_q;
  assign r_valid_o  = r_valid_q;
  assign r_last_o   = r_last_q;
  assign r_id_o     = r_id_q;
  assign r_resp_o   = AxiRespDecErr;
  assign r_data_o   = r_valid_q ? DataWidth'(DecErrRdata) : '0;

endmodule

// File: rtl/soc_decerr_slave.sv
// AXI4 crossbar default slave: answers every burst with DECERR.
// Optional first-error address capture under SOC_DECERR_CAPTURE_EN.
module soc_decerr_slave
  import ariane_soc::*;
#(
  parameter int unsigned IdWidth   = IdWidthSlave,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic                 w_last_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic                 err_valid_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_is_write_o,
  input  logic                 err_clear_i
);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  wstate_e            wstate_q;
  logic               aw_ready_q;
  logic               w_ready_q;
  logic               b_valid_q;
  logic [IdWidth-1:0] b_id_q;

  // Write FSM: take AW, swallow W beats until last, then hold B
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wstate_q   <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
    end else begin
      unique case (wstate_q)
        W_IDLE: begin
          if (aw_valid_i) begin
            wstate_q   <= W_DATA;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            b_id_q     <= aw_id_i;
          end
        end
        W_DATA: begin
          if (w_valid_i && w_last_i) begin
            wstate_q  <= W_RESP;
            w_ready_q <= 1'b0;
            b_valid_q <= 1'b1;
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            wstate_q   <= W_IDLE;
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_id_o     = b_id_q;
  assign b_resp_o   = AxiRespDecErr;

  soc_decerr_rd_gen #(
    .IdWidth   (IdWidth),
    .DataWidth (DataWidth)
  ) u_rd_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ar_id_i    (ar_id_i),
    .ar_len_i   (ar_len_i),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .r_id_o     (r_id_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_last_o   (r_last_o),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i)
  );

`ifdef SOC_DECERR_CAPTURE_EN
  logic                 aw_hs;
  logic                 ar_hs;
  logic                 arm;
  logic                 err_valid_q;
  logic                 err_is_write_q;
  logic [AddrWidth-1:0] err_addr_q;

  assign aw_hs = aw_valid_i && aw_ready_o;
  assign ar_hs = ar_valid_i && ar_ready_o;
  assign arm   = !err_valid_q || err_clear_i;

  // First-error capture; writes win a same-cycle tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_q    <= 1'b0;
      err_is_write_q <= 1'b0;
      err_addr_q     <= '0;
    end else if (arm && aw_hs) begin
      err_valid_q    <= 1'b1;
      err_is_write_q <= 1'b1;
      err_addr_q     <= aw_addr_i;
    end else if (arm && ar_hs) begin
      err_valid_q    <= 1'b1;
      err_is_write_q <= 1'b0;
      err_addr_q     <= ar_addr_i;
    end else if (err_clear_i) begin
      err_valid_q    <= 1'b0;
      err_is_write_q <= 1'b0;
      err_addr_q     <= '0;
    end
  end

  assign err_valid_o    = err_valid_q;
  assign err_is_write_o = err_is_write_q;
  assign err_addr_o     = err_addr_q;
`else
  logic unused_cap;
  assign unused_cap     = ^{aw_addr_i, ar_addr_i, err_clear_i};
  assign err_valid_o    = 1'b0;
  assign err_is_write_o = 1'b0;
  assign err_addr_o     = '0;
`endif

endmodule

// File: tb/tb_soc_decerr_slave.sv
// Directed bench for soc_decerr_slave with an R/B scoreboard.
// Capture checks follow SOC_DECERR_CAPTURE_EN.
module tb_soc_decerr_slave;

  localparam logic [63:0] RDATA = 64'hBADCAB1EBADCAB1E;

  typedef struct packed {
    logic [5:0] id;
    logic       last;
  } rexp_t;

  logic        clk;
  logic        rst;
  logic [5:0]  aw_id;
  logic [63:0] aw_addr;
  logic        aw_valid, aw_ready;
  logic        w_last, w_valid, w_ready;
  logic [5:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready;
  logic [5:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic        ar_valid, ar_ready;
  logic [5:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last, r_valid, r_ready;
  logic        err_valid;
  logic [63:0] err_addr;
  logic        err_is_write;
  logic        err_clear;

  int n_cmp = 0;
  int n_err = 0;
  int w_acc = 0;
  int w_base;

  rexp_t      rq[$];
  logic [5:0] bq[$];

  soc_decerr_slave dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .aw_id_i        (aw_id),
    .aw_addr_i      (aw_addr),
    .aw_valid_i     (aw_valid),
    .aw_ready_o     (aw_ready),
    .w_last_i       (w_last),
    .w_valid_i      (w_valid),
    .w_ready_o      (w_ready),
    .b_id_o         (b_id),
    .b_resp_o       (b_resp),
    .b_valid_o      (b_valid),
    .b_ready_i      (b_ready),
    .ar_id_i        (ar_id),
    .ar_addr_i      (ar_addr),
    .ar_len_i       (ar_len),
    .ar_valid_i     (ar_valid),
    .ar_ready_o     (ar_ready),
    .r_id_o         (r_id),
    .r_data_o       (r_data),
    .r_resp_o       (r_resp),
    .r_last_o       (r_last),
    .r_valid_o      (r_valid),
    .r_ready_i      (r_ready),
    .err_valid_o    (err_valid),
    .err_addr_o     (err_addr),
    .err_is_write_o (err_is_write),
    .err_clear_i    (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (w_valid && w_ready) w_acc <= w_acc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input logic v, input logic [63:0] a,
                         input logic w);
`ifdef SOC_DECERR_CAPTURE_EN
    chk("err_valid", err_valid, v);
    chk("err_addr", err_addr, a);
    chk("err_is_write", err_is_write, w);
`else
    chk("err_valid_tied", err_valid, 1'b0);
    chk("err_addr_tied", err_addr, 64'd0);
    chk("err_is_write_tied", err_is_write, 1'b0);
`endif
  endtask

  task automatic issue_ar(input logic [5:0] id, input logic [7:0] len,
                          input logic [63:0] addr);
    chk("ar_ready_idle", ar_ready, 1'b1);
    for (int b = 0; b <= int'(len); b++)
      rq.push_back('{id: id, last: (b == int'(len))});
    ar_id    = id;
    ar_len   = len;
    ar_addr  = addr;
    ar_valid = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0;
    chk("r_first_latency", r_valid, 1'b1);
  endtask

  task automatic drain_r(input int nbeats);
    int          got;
    int          t;
    bit          stalled;
    rexp_t       e;
    logic [5:0]  s_id;
    logic [63:0] s_data;
    logic        s_last;
    logic [1:0]  s_resp;
    got     = 0;
    t       = 0;
    stalled = 1'b0;
    while (got < nbeats && t < 3000) begin
      @(negedge clk);
      t++;
      r_ready = 1'($urandom_range(0, 1));
      if (r_valid) begin
        if (stalled) begin
          chk("r_stall_id", r_id, s_id);
          chk("r_stall_data", r_data, s_data);
          chk("r_stall_last", r_last, s_last);
          chk("r_stall_resp", r_resp, s_resp);
        end
        if (r_ready) begin
          if (rq.size() == 0) begin
            chk("r_unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = rq.pop_front();
            chk("r_id", r_id, e.id);
            chk("r_last", r_last, e.last);
            chk("r_data", r_data, RDATA);
            chk("r_resp", r_resp, 2'b11);
          end
          got++;
        end
        stalled = !r_ready;
        s_id    = r_id;
        s_data  = r_data;
        s_last  = r_last;
        s_resp  = r_resp;
      end else begin
        stalled = 1'b0;
      end
    end
    if (got < nbeats) chk("r_drain_timeout", got, nbeats);
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    aw_id = '0; aw_addr = '0; aw_valid = 1'b0;
    w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 1'b0;
    r_ready = 1'b0; err_clear = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_aw_ready", aw_ready, 1'b1);
    chk("rst_ar_ready", ar_ready, 1'b1);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_r_last", r_last, 1'b0);
    chk("rst_b_id", b_id, 6'd0);
    chk("rst_r_id", r_id, 6'd0);
    chk_err(1'b0, 64'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // W before AW is not accepted
    w_base  = w_acc;
    w_valid = 1'b1;
    w_last  = 1'b1;
    @(negedge clk);
    chk("w_early_ready", w_ready, 1'b0);
    w_valid = 1'b0;
    @(negedge clk);
    chk("w_early_accepts", w_acc - w_base, 0);

    // AW id 5 with a 4-beat write burst
    w_base   = w_acc;
    aw_id    = 6'd5;
    aw_addr  = 64'h0000_0000_7000_0040;
    aw_valid = 1'b1;
    bq.push_back(6'd5);
    @(negedge clk);
    aw_valid = 1'b0;
    chk("aw_ready_busy", aw_ready, 1'b0);
    chk_err(1'b1, 64'h0000_0000_7000_0040, 1'b1);
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1;
      w_last  = (i == 3);
      t = 0;
      while (!w_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    chk("b_valid_latency", b_valid, 1'b1);
    chk("w_accepts", w_acc - w_base, 4);
    if (bq.size() != 0) chk("b_id", b_id, bq.pop_front());
    chk("b_resp", b_resp, 2'b11);
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    chk("b_valid_done", b_valid, 1'b0);
    chk("aw_ready_back", aw_ready, 1'b1);

    // AR single beat
    issue_ar(6'd3, 8'd0, 64'h0000_0000_7100_0000);
    chk("r_single_last", r_last, 1'b1);
    drain_r(1);
    chk("r_single_done", r_valid, 1'b0);

    // AR 256 beats with random stalls
    issue_ar(6'd7, 8'd255, 64'h0000_0000_7200_0000);
    drain_r(256);
    chk("r_256_done", r_valid, 1'b0);
    chk("r_256_queue", rq.size(), 0);

    // Clear capture before the concurrent test
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk_err(1'b0, 64'd0, 1'b0);

    // AW and AR together, B stalled
    for (int b = 0; b <= 3; b++)
      rq.push_back('{id: 6'd10, last: (b == 3)});
    bq.push_back(6'd9);
    aw_id = 6'd9;  aw_addr = 64'h0000_0000_7300_0100; aw_valid = 1'b1;
    ar_id = 6'd10; ar_addr = 64'h0000_0000_7400_0200; ar_len = 8'd3;
    ar_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0;
    ar_valid = 1'b0;
    chk("dual_r_valid", r_valid, 1'b1);
    chk_err(1'b1, 64'h0000_0000_7300_0100, 1'b1);
    w_valid = 1'b1;
    w_last  = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    w_last  = 1'b0;
    chk("dual_b_valid", b_valid, 1'b1);
    drain_r(4);
    chk("dual_r_done", r_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("b_held", b_valid, 1'b1);
      @(negedge clk);
    end
    if (bq.size() != 0) chk("dual_b_id", b_id, bq.pop_front());
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    chk("dual_b_done", b_valid, 1'b0);

    // Reset at beat 7 of 16
    issue_ar(6'd12, 8'd15, 64'h0000_0000_7500_0000);
    drain_r(6);
    chk("mid_r_valid", r_valid, 1'b1);
    chk("mid_r_last", r_last, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_r_valid", r_valid, 1'b0);
    chk("rst_mid_ar_ready", ar_ready, 1'b1);
    chk("rst_mid_r_id", r_id, 6'd0);
    chk_err(1'b0, 64'd0, 1'b0);
    rq.delete();
    issue_ar(6'd4, 8'd1, 64'h0000_0000_1000_0000);
    chk("fresh_first_last", r_last, 1'b0);
    drain_r(2);
    chk("fresh_queue", rq.size(), 0);
    chk_err(1'b1, 64'h0000_0000_1000_0000, 1'b0);

    // Second error without clear leaves capture alone
    issue_ar(6'd1, 8'd0, 64'h0000_0000_2000_0000);
    drain_r(1);
    chk_err(1'b1, 64'h0000_0000_1000_0000, 1'b0);

    // Clear together with a new AR captures the new one
    err_clear = 1'b1;
    issue_ar(6'd2, 8'd0, 64'h0000_0000_5000_2000);
    err_clear = 1'b0;
    chk_err(1'b1, 64'h0000_0000_5000_2000, 1'b0);
    drain_r(1);
    chk("final_queue", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
